// File: rtl/dmem_responder.sv
// Load/store responder between the execute stage and a simple request/ack bus.
// Accepts one RV32 load or store at a time, drives word-aligned bus beats and returns extended load data.
module dmem_responder #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              mem_busy,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              access_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

    state_t              r_state;
    logic                r_busy;
    logic [31:0]         r_rdata;
    logic                r_rdata_valid;
    logic                r_access_err;
    logic                r_bus_req;
    logic                r_bus_we;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [3:0]          r_bus_be;
    logic [31:0]         r_bus_wdata;
    logic [2:0]          r_func3;
    logic [1:0]          r_offset;
    logic [7:0]          r_cnt;

    logic                w_illegal;
    logic                w_misaligned;
    logic                w_req_err;
    logic [3:0]          w_be;
    logic [31:0]         w_lanes;
    logic [31:0]         w_shifted;
    logic [31:0]         w_load_ext;

    // Width/alignment decode of the request currently presented.
    assign w_illegal    = (func3 == 3'b011) || (func3[2:1] == 2'b11);
    assign w_misaligned = ((func3[1:0] == 2'b01) && addr[0]) ||
                          ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    assign w_req_err    = w_illegal || w_misaligned;

    always_comb begin
        w_be = 4'b1111;
        case (func3[1:0])
            2'b00:   w_be = 4'b0001 << addr[1:0];
            2'b01:   w_be = 4'b0011 << addr[1:0];
            default: w_be = 4'b1111;
        endcase
    end

    // Each byte lane carries the store byte that lands there for any legal offset.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            always_comb begin
                w_lanes[8*gi +: 8] = wdata[8*gi +: 8];
                case (func3[1:0])
                    2'b00:   w_lanes[8*gi +: 8] = wdata[7:0];
                    2'b01:   w_lanes[8*gi +: 8] = wdata[8*(gi%2) +: 8];
                    default: w_lanes[8*gi +: 8] = wdata[8*gi +: 8];
                endcase
            end
        end
    endgenerate

    assign w_shifted = bus_rdata >> {r_offset, 3'b000};

    always_comb begin
        w_load_ext = w_shifted;
        case (r_func3)
            3'b000:  w_load_ext = {{24{w_shifted[7]}},  w_shifted[7:0]};
            3'b001:  w_load_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_ext = {24'd0, w_shifted[7:0]};
            3'b101:  w_load_ext = {16'd0, w_shifted[15:0]};
            default: w_load_ext = w_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_access_err  <= 1'b0;
            r_bus_req     <= 1'b0;
            r_bus_we      <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_be      <= '0;
            r_bus_wdata   <= '0;
            r_func3       <= '0;
            r_offset      <= '0;
            r_cnt         <= '0;
        end else begin
            r_rdata_valid <= 1'b0;
            r_access_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A simultaneous store is left pending; the requester keeps wr_req up.
                    if (rd_req || wr_req) begin
                        if (w_req_err) begin
                            r_access_err <= 1'b1;
                            if (rd_req) begin
                                r_rdata_valid <= 1'b1;
                                r_rdata       <= '0;
                            end
                        end else begin
                            r_state     <= rd_req ? READ : WRITE;
                            r_busy      <= 1'b1;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= ~rd_req;
                            r_bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            r_bus_be    <= w_be;
                            r_bus_wdata <= w_lanes;
                            r_func3     <= func3;
                            r_offset    <= addr[1:0];
                            r_cnt       <= '0;
                        end
                    end
                end
                WRITE, READ: begin
                    // An ack arriving on the last allowed cycle still completes normally.
                    if (bus_ack) begin
                        r_bus_req <= 1'b0;
                        if (r_state == READ) begin
                            r_rdata       <= w_load_ext;
                            r_rdata_valid <= 1'b1;
                            r_state       <= RESP;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_bus_req    <= 1'b0;
                        r_busy       <= 1'b0;
                        r_access_err <= 1'b1;
                        r_state      <= IDLE;
                        if (r_state == READ) begin
                            r_rdata_valid <= 1'b1;
                            r_rdata       <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_busy    = r_busy;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign access_err  = r_access_err;
    assign bus_req     = r_bus_req;
    assign bus_we      = r_bus_we;
    assign bus_addr    = r_bus_addr;
    assign bus_be      = r_bus_be;
    assign bus_wdata   = r_bus_wdata;

endmodule
